// File: rtl/mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_slot_arbiter
//  Purpose  : Slot-paced arbiter sharing one external SRAM between a video
//             reader, the CPU and a loader/DMA engine. Each granted access
//             runs SETUP -> STROBE -> DONE and ends with a one-clock ack.
//  Revision : 1.0  initial release
// ============================================================================
module mem_slot_arbiter #(
    parameter int AW     = 19,
    parameter int STARVE = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          slot,
    input  logic          vreq,
    input  logic [AW-1:0] vaddr,
    input  logic          creq,
    input  logic          cwr,
    input  logic [AW-1:0] caddr,
    input  logic [7:0]    cdi,
    input  logic          lreq,
    input  logic          lwr,
    input  logic [AW-1:0] laddr,
    input  logic [7:0]    ldi,
    output logic          vack,
    output logic          cack,
    output logic          lack,
    output logic [7:0]    q,
    output logic [AW-1:0] ma,
    output logic          mwe_n,
    output logic [7:0]    md_o,
    output logic          md_oe,
    input  logic [7:0]    md_i
);

    localparam int CW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] C_STARVE = CW'(STARVE);

    localparam logic [1:0] C_GNT_V = 2'd0;
    localparam logic [1:0] C_GNT_C = 2'd1;
    localparam logic [1:0] C_GNT_L = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q,  state_d;
    logic [1:0]      gnt_q,    gnt_d;
    logic            wr_q,     wr_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic [AW-1:0]   ma_q,     ma_d;
    logic [7:0]      md_o_q,   md_o_d;
    logic            md_oe_q,  md_oe_d;
    logic            mwe_n_q,  mwe_n_d;
    logic [2:0]      ack_q,    ack_d;
    logic [7:0]      q_q,      q_d;

    logic [1:0]      w_sel;
    logic            w_sel_wr;
    logic [AW-1:0]   w_sel_addr;
    logic [7:0]      w_sel_data;
    logic            w_any_req;
    logic            w_sample;

    // Winner selection: a starved loader overrides the fixed video > CPU > loader order
    always_comb begin
        w_any_req  = vreq | creq | lreq;
        w_sample   = (state_q == ST_IDLE) && slot;
        w_sel      = C_GNT_L;
        if (lreq && (starve_q >= C_STARVE)) begin
            w_sel = C_GNT_L;
        end else if (vreq) begin
            w_sel = C_GNT_V;
        end else if (creq) begin
            w_sel = C_GNT_C;
        end
        w_sel_wr   = 1'b0;
        w_sel_addr = laddr;
        w_sel_data = ldi;
        case (w_sel)
            C_GNT_V: begin
                w_sel_wr   = 1'b0;
                w_sel_addr = vaddr;
                w_sel_data = md_o_q;      // video never writes; leave bus data alone
            end
            C_GNT_C: begin
                w_sel_wr   = cwr;
                w_sel_addr = caddr;
                w_sel_data = cdi;
            end
            default: begin
                w_sel_wr   = lwr;
                w_sel_addr = laddr;
                w_sel_data = ldi;
            end
        endcase
    end

    // Loader starvation counter: reset when the loader is idle or wins, saturates otherwise
    always_comb begin
        starve_d = starve_q;
        if (!lreq) begin
            starve_d = '0;
        end else if (w_sample) begin
            if (w_sel == C_GNT_L) begin
                starve_d = '0;
            end else if (starve_q != C_STARVE) begin
                starve_d = starve_q + CW'(1);
            end
        end
    end

    // Access sequencer: next state and registered SRAM/ack outputs
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        ma_d    = ma_q;
        md_o_d  = md_o_q;
        md_oe_d = md_oe_q;
        mwe_n_d = 1'b1;
        ack_d   = 3'b000;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (slot && w_any_req) begin
                    state_d = ST_SETUP;
                    gnt_d   = w_sel;
                    wr_d    = w_sel_wr;
                    ma_d    = w_sel_addr;
                    md_o_d  = w_sel_data;
                    md_oe_d = w_sel_wr;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                mwe_n_d = ~wr_q;
            end
            ST_STROBE: begin
                state_d = ST_DONE;
                case (gnt_q)
                    C_GNT_V: ack_d = 3'b001;
                    C_GNT_C: ack_d = 3'b010;
                    default: ack_d = 3'b100;
                endcase
                // Address has been stable since SETUP, so read data is valid here
                if (!wr_q) begin
                    q_d = md_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
                md_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= C_GNT_V;
            wr_q     <= 1'b0;
            starve_q <= '0;
            ma_q     <= '0;
            md_o_q   <= 8'h00;
            md_oe_q  <= 1'b0;
            mwe_n_q  <= 1'b1;
            ack_q    <= 3'b000;
            q_q      <= 8'h00;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            wr_q     <= wr_d;
            starve_q <= starve_d;
            ma_q     <= ma_d;
            md_o_q   <= md_o_d;
            md_oe_q  <= md_oe_d;
            mwe_n_q  <= mwe_n_d;
            ack_q    <= ack_d;
            q_q      <= q_d;
        end
    end

    assign vack  = ack_q[0];
    assign cack  = ack_q[1];
    assign lack  = ack_q[2];
    assign q     = q_q;
    assign ma    = ma_q;
    assign mwe_n = mwe_n_q;
    assign md_o  = md_o_q;
    assign md_oe = md_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_slot_arbiter
//  Purpose  : Directed and random stimulus for mem_slot_arbiter against a
//             transaction-level reference model (grant time + cycle offset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_slot_arbiter;

    localparam int AW     = 19;
    localparam int STARVE = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          slot  = 1'b0;
    logic          vreq  = 1'b0, creq = 1'b0, lreq = 1'b0;
    logic          cwr   = 1'b0, lwr  = 1'b0;
    logic [AW-1:0] vaddr = '0, caddr = '0, laddr = '0;
    logic [7:0]    cdi   = 8'h00, ldi = 8'h00;
    logic          vack, cack, lack, mwe_n, md_oe;
    logic [7:0]    q, md_o, md_i;
    logic [AW-1:0] ma;
    logic          md_ovr_en = 1'b0;
    logic [7:0]    md_ovr    = 8'h00;

    always #5 clock = ~clock;

    // SRAM read data is a fixed function of the address (or a forced value)
    assign md_i = md_ovr_en ? md_ovr : (ma[7:0] ^ ma[15:8] ^ 8'h5A);

    mem_slot_arbiter #(.AW(AW), .STARVE(STARVE)) dut (
        .clock(clock), .reset(reset), .slot(slot),
        .vreq(vreq), .vaddr(vaddr),
        .creq(creq), .cwr(cwr), .caddr(caddr), .cdi(cdi),
        .lreq(lreq), .lwr(lwr), .laddr(laddr), .ldi(ldi),
        .vack(vack), .cack(cack), .lack(lack), .q(q),
        .ma(ma), .mwe_n(mwe_n), .md_o(md_o), .md_oe(md_oe), .md_i(md_i)
    );

    // Reference model: k = clocks since the grant edge (1..3), -1 when no access
    int            k = -1;
    int            starve_m = 0;
    int            gw = 0;
    logic          gwr = 1'b0;
    logic [AW-1:0] gaddr = '0, exp_ma = '0;
    logic [7:0]    gdata = 8'h00, exp_q = 8'h00;
    logic          was_reset = 1'b0;

    int vectors = 0, miscompares = 0;
    int since = 100;
    int ack_seen [3] = '{0, 0, 0};

    function automatic logic [7:0] rd_val(input logic [AW-1:0] a);
        return md_ovr_en ? md_ovr : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the arbitration rules to the inputs present before the coming edge
    task automatic model_edge();
        bit sampled, granted_l;
        was_reset = reset;
        granted_l = 1'b0;
        if (reset) begin
            k = -1; starve_m = 0; exp_ma = '0; exp_q = 8'h00;
        end else begin
            sampled = (k == -1) && slot;
            if (k == 3) begin
                k = -1;
            end else if (k >= 1) begin
                k++;
                if (k == 3 && !gwr) exp_q = rd_val(gaddr);
            end else if (sampled && (vreq || creq || lreq)) begin
                if (lreq && starve_m >= STARVE) gw = 2;
                else if (vreq)                  gw = 0;
                else if (creq)                  gw = 1;
                else                            gw = 2;
                case (gw)
                    0:       begin gwr = 1'b0; gaddr = vaddr; gdata = 8'h00; end
                    1:       begin gwr = cwr;  gaddr = caddr; gdata = cdi;   end
                    default: begin gwr = lwr;  gaddr = laddr; gdata = ldi;   end
                endcase
                granted_l = (gw == 2);
                exp_ma = gaddr;
                k = 1;
            end
            if (!lreq)            starve_m = 0;
            else if (sampled)     starve_m = granted_l ? 0 : ((starve_m + 1 > STARVE) ? STARVE : starve_m + 1);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] exp_ack;
        exp_ack = (k == 3) ? (3'b001 << gw) : 3'b000;
        chk("ack", {29'd0, lack, cack, vack}, {29'd0, exp_ack});
        chk("mwe_n", {31'd0, mwe_n}, {31'd0, !(k == 2 && gwr)});
        chk("md_oe", {31'd0, md_oe}, {31'd0, (k >= 1 && gwr)});
        chk("ma", 32'(ma), 32'(exp_ma));
        if (k >= 1 && gwr) chk("md_o", {24'd0, md_o}, {24'd0, gdata});
        if (was_reset)     chk("md_o_rst", {24'd0, md_o}, 32'd0);
        if (k == -1)       chk("q", {24'd0, q}, {24'd0, exp_q});
    endtask

    // One clock: model, edge, check, then release the acked requester and slot
    task automatic cyc();
        if (slot) since = 0; else since++;
        model_edge();
        @(posedge clock);
        #1;
        check_outputs();
        ack_seen[0] += int'(vack);
        ack_seen[1] += int'(cack);
        ack_seen[2] += int'(lack);
        if (k == 3) begin
            case (gw)
                0:       vreq = 1'b0;
                1:       creq = 1'b0;
                default: lreq = 1'b0;
            endcase
        end
        slot = 1'b0;
    endtask

    initial begin
        int c0, lack_iter;

        // Reset with a CPU write pending and a slot pulse inside reset
        reset = 1'b1;
        creq = 1'b1; cwr = 1'b1; caddr = 19'h04000; cdi = 8'hA5;
        cyc();
        slot = 1'b1; cyc();
        cyc();
        reset = 1'b0;
        repeat (3) cyc();               // no grant without a fresh slot

        // CPU write
        slot = 1'b1; cyc();
        repeat (5) cyc();

        // Video read with forced SRAM data
        md_ovr_en = 1'b1; md_ovr = 8'h3C;
        vreq = 1'b1; vaddr = 19'h05800;
        slot = 1'b1; cyc();
        repeat (5) cyc();
        md_ovr_en = 1'b0;

        // Slot with nobody requesting
        slot = 1'b1; cyc();
        repeat (4) cyc();

        // Everybody requesting: video wins until the loader starves
        creq = 1'b1; cwr = 1'b0; caddr = 19'h12345;
        lreq = 1'b1; lwr = 1'b1; laddr = 19'h7ABCD; ldi = 8'h96;
        lack_iter = 0;
        for (int it = 1; it <= 9; it++) begin
            vreq = 1'b1; vaddr = AW'(19'h01000 + it);
            c0 = ack_seen[2];
            slot = 1'b1; cyc();
            repeat (3) cyc();
            if (ack_seen[2] != c0 && lack_iter == 0) lack_iter = it;
        end
        chk("starve_grant_slot", 32'(lack_iter), 32'd9);
        vreq = 1'b0;
        slot = 1'b1; cyc();             // CPU finally served
        repeat (4) cyc();

        // Slot one clock after a grant is ignored
        creq = 1'b1; cwr = 1'b0; caddr = 19'h2AAAA;
        c0 = ack_seen[1];
        slot = 1'b1; cyc();
        slot = 1'b1; cyc();
        repeat (5) cyc();
        chk("single_ack", 32'(ack_seen[1] - c0), 32'd1);

        // Reset during STROBE of a CPU write abandons it
        creq = 1'b1; cwr = 1'b1; caddr = 19'h04444; cdi = 8'h3B;
        c0 = ack_seen[1];
        slot = 1'b1; cyc();
        cyc();                          // now in STROBE
        reset = 1'b1; cyc();
        reset = 1'b0;
        repeat (3) cyc();
        chk("no_ack_after_abort", 32'(ack_seen[1] - c0), 32'd0);
        slot = 1'b1; cyc();
        repeat (4) cyc();

        // Request dropped mid-access still completes
        creq = 1'b1; cwr = 1'b0; caddr = 19'h0F0F0;
        c0 = ack_seen[1];
        slot = 1'b1; cyc();
        creq = 1'b0;
        repeat (4) cyc();
        chk("ack_after_drop", 32'(ack_seen[1] - c0), 32'd1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if (!vreq && ($urandom % 4 == 0)) begin
                vreq = 1'b1; vaddr = AW'($urandom);
            end
            if (!creq && ($urandom % 4 == 0)) begin
                creq = 1'b1; cwr = 1'($urandom); caddr = AW'($urandom); cdi = 8'($urandom);
            end
            if (!lreq && ($urandom % 4 == 0)) begin
                lreq = 1'b1; lwr = 1'($urandom); laddr = AW'($urandom); ldi = 8'($urandom);
            end
            if (since >= 3 && ($urandom % 3 == 0)) slot = 1'b1;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
